// File: rtl/shift_add_mult_arbiter.sv
// Round-robin front end that time-shares one sequential shift-add multiplier
// between NUM_REQ requesters over valid/ready, with a done/timeout handshake.
module shift_add_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         reqValid,
  input  logic [NUM_REQ*WIDTH-1:0]   reqA,
  input  logic [NUM_REQ*WIDTH-1:0]   reqB,
  output logic [NUM_REQ-1:0]         reqReady,
  output logic [NUM_REQ-1:0]         respValid,
  output logic [2*WIDTH-1:0]         respResult,
  output logic                       respError,
  output logic                       busy,
  output logic                       mulRst,
  output logic [WIDTH-1:0]           mulA,
  output logic [WIDTH-1:0]           mulB,
  input  logic                       mulEnd,
  input  logic [2*WIDTH-1:0]         mulResult
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]   NREQ_X   = (IDX_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   gnt_sel;
  logic               gnt_any;
  logic [CNT_W-1:0]   wait_cnt;
  logic               end_hit;
  logic               tmo_hit;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Circular search: walking k downwards leaves the first hit at or after ptr.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    logic [IDX_W:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDX_W+1)'(k);
      if (idx >= NREQ_X) idx = idx - NREQ_X;
      if (req[idx[IDX_W-1:0]]) res = {1'b1, idx[IDX_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    logic [IDX_W:0] n;
    n = {1'b0, g} + (IDX_W+1)'(1);
    if (n >= NREQ_X) n = '0;
    return n[IDX_W-1:0];
  endfunction

  assign {gnt_any, gnt_sel} = rr_pick(reqValid, rr_ptr);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_sel == IDX_W'(i)) begin
        sel_a = reqA[i*WIDTH +: WIDTH];
        sel_b = reqB[i*WIDTH +: WIDTH];
      end
    end
  end

  // The first WAIT cycle (count 0) may still see a stale done flag.
  assign end_hit = (state == WAIT) && (wait_cnt != '0) && mulEnd;
  assign tmo_hit = (state == WAIT) && (wait_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (end_hit || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A grant offered while reset is asserted would be lost, so it is withheld.
  always_comb begin
    reqReady  = '0;
    respValid = '0;
    busy      = 1'b1;
    mulRst    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (gnt_any && !rst) reqReady[gnt_sel] = 1'b1;
      end
      WAIT:    mulRst = 1'b0;
      DONE:    respValid[gnt_idx] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      wait_cnt   <= '0;
      mulA       <= '0;
      mulB       <= '0;
      respResult <= '0;
      respError  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            gnt_idx <= gnt_sel;
            mulA    <= sel_a;
            mulB    <= sel_b;
          end
        end
        START: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (end_hit) begin
            respResult <= mulResult;
            respError  <= 1'b0;
          end else if (tmo_hit) begin
            respResult <= '0;
            respError  <= 1'b1;
          end
        end
        DONE:    rr_ptr <= rr_next(gnt_idx);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_arbiter.sv
// Bench for shift_add_mult_arbiter: a transaction-level reference model watches
// every cycle while directed and random requesters drive the arbiter.
module tb_shift_add_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     reqValid;
  logic [N*W-1:0]   reqA;
  logic [N*W-1:0]   reqB;
  logic [N-1:0]     reqReady;
  logic [N-1:0]     respValid;
  logic [2*W-1:0]   respResult;
  logic             respError;
  logic             busy;
  logic             mulRst;
  logic [W-1:0]     mulA;
  logic [W-1:0]     mulB;
  logic             mulEnd;
  logic [2*W-1:0]   mulResult;

  shift_add_mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqA(reqA), .reqB(reqB),
    .reqReady(reqReady), .respValid(respValid), .respResult(respResult),
    .respError(respError), .busy(busy), .mulRst(mulRst), .mulA(mulA),
    .mulB(mulB), .mulEnd(mulEnd), .mulResult(mulResult)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product ready W cycles after restart is released.
  int   mcnt = 0;
  logic stale_hi = 1'b0;
  logic never_end = 1'b0;
  always @(posedge clk) begin
    if (mulRst)       mcnt <= 0;
    else if (mcnt < W) mcnt <= mcnt + 1;
  end
  assign mulEnd    = stale_hi | (!never_end && !mulRst && mcnt == W);
  assign mulResult = stale_hi ? 16'hdead : ({8'b0, mulA} * {8'b0, mulB});

  int errs = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  // Reference model: one outstanding transaction, timing from accept cycle T.
  int   mc = 0;
  bit   mon_en = 0;
  bit   m_inf = 0;
  int   m_T, m_g, m_a, m_b, m_done, m_res, m_err;
  int   m_ptr = 0;
  int   g_m;
  logic [N-1:0] e_rdy, e_rsp;
  bit   e_wait;
  int   log_g[$], log_res[$], log_err[$], log_lat[$], grant_q[$];

  initial forever begin
    @(negedge clk);
    mc++;
    if (mon_en) begin
      g_m    = (rst || m_inf) ? -1 : rr_pick(m_ptr, reqValid);
      e_rdy  = (g_m >= 0) ? onehot(g_m) : '0;
      e_wait = m_inf && (mc >= m_T + 2) && (m_done < 0 || mc < m_done);
      e_rsp  = (m_inf && mc == m_done) ? onehot(m_g) : '0;
      check_val("reqReady", reqReady, e_rdy);
      check_val("respValid", respValid, e_rsp);
      check_val("busy", busy, m_inf);
      check_val("mulRst", mulRst, !e_wait);
      if (e_wait) begin
        check_val("mulA", mulA, m_a);
        check_val("mulB", mulB, m_b);
      end
      if (e_rsp != '0) begin
        check_val("respResult", respResult, m_res);
        check_val("respError", respError, m_err);
        log_g.push_back(m_g);
        log_res.push_back(int'(respResult));
        log_err.push_back(int'(respError));
        log_lat.push_back(mc - m_T);
        m_ptr = (m_g + 1) % N;
        m_inf = 0;
      end else if (e_wait && m_done < 0) begin
        if (mc >= m_T + 3 && mulEnd) begin
          m_done = mc + 1; m_res = m_a * m_b; m_err = 0;
        end else if (mc == m_T + 1 + TO) begin
          m_done = mc + 1; m_res = 0; m_err = 1;
        end
      end else if (g_m >= 0) begin
        m_inf = 1; m_T = mc; m_g = g_m; m_done = -1;
        m_a = int'(reqA[g_m*W +: W]);
        m_b = int'(reqB[g_m*W +: W]);
        grant_q.push_back(g_m);
      end
      if (rst) begin
        m_inf = 0;
        m_ptr = 0;
      end
    end
  end

  bit auto_mode = 0;

  task automatic post(input int i, input int a, input int b);
    reqA[i*W +: W] = W'(a);
    reqB[i*W +: W] = W'(b);
    reqValid[i] = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0] acc, rv;
    @(negedge clk);
    acc = reqReady;
    rv  = respValid;
    @(posedge clk);
    #1;
    reqValid = reqValid & ~acc;
    if (auto_mode)
      for (int i = 0; i < N; i++)
        if (rv[i]) post(i, $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic wait_resp(input int n, input int budget);
    int k = 0;
    while (log_g.size() < n && k < budget) begin
      step();
      k++;
    end
    if (log_g.size() < n) check_val("resp_wait", log_g.size(), n);
  endtask

  task automatic wait_grant(input int n, input int budget);
    int k = 0;
    while (grant_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (grant_q.size() < n) check_val("grant_wait", grant_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, gb, k, prev, others;
    int exp_r[4];
    rst = 1'b1; reqValid = '0; reqA = '0; reqB = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_reqReady", reqReady, 0);
    check_val("rst_respValid", respValid, 0);
    check_val("rst_respResult", respResult, 0);
    check_val("rst_respError", respError, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_mulRst", mulRst, 1);
    check_val("rst_mulA", mulA, 0);
    check_val("rst_mulB", mulB, 0);
    rst = 1'b0;
    mon_en = 1;

    // Single request 3*5 from requester 1
    b = log_g.size();
    post(1, 3, 5);
    wait_resp(b + 1, 60);
    check_val("t1_grant", log_g[b], 1);
    check_val("t1_result", log_res[b], 15);
    check_val("t1_error", log_err[b], 0);

    // All four together after reset
    rst = 1'b1; step(); rst = 1'b0;
    b = log_g.size();
    post(0, 10, 12); post(1, 127, 201); post(2, 255, 255); post(3, 0, 77);
    exp_r = '{120, 25527, 65025, 0};
    wait_resp(b + 4, 200);
    for (int i = 0; i < 4; i++) begin
      check_val("t2_grant", log_g[b+i], i);
      check_val("t2_result", log_res[b+i], exp_r[i]);
    end

    // After a grant to 2, requester 3 precedes requester 0
    b = log_g.size();
    post(2, 4, 9);
    wait_resp(b + 1, 60);
    post(0, 11, 2); post(3, 7, 8);
    wait_resp(b + 3, 120);
    check_val("t3_first", log_g[b+1], 3);
    check_val("t3_second", log_g[b+2], 0);
    check_val("t3_res3", log_res[b+1], 56);

    // Continuous random traffic on all four requesters
    gb = grant_q.size();
    b = log_g.size();
    for (int i = 0; i < N; i++) post(i, $urandom_range(0, 255), $urandom_range(0, 255));
    auto_mode = 1;
    wait_resp(b + 20, 800);
    auto_mode = 0;
    k = 0;
    while ((reqValid != '0 || busy) && k < 400) begin
      step();
      k++;
    end
    check_val("t4_drain", {reqValid, busy}, 0);
    for (int j = gb; j < grant_q.size(); j++) begin
      prev = -1;
      for (int q = gb; q < j; q++) if (grant_q[q] == grant_q[j]) prev = q;
      if (prev >= 0) begin
        others = j - prev - 1;
        check_val("t4_fair", int'(others <= 3), 1);
      end
    end

    // Timeout, then normal completion
    never_end = 1'b1;
    b = log_g.size();
    post(2, 9, 9);
    wait_resp(b + 1, 60);
    check_val("t5_error", log_err[b], 1);
    check_val("t5_result", log_res[b], 0);
    check_val("t5_latency", log_lat[b], TO + 2);
    never_end = 1'b0;
    post(0, 13, 11);
    wait_resp(b + 2, 60);
    check_val("t5_next_res", log_res[b+1], 143);
    check_val("t5_next_err", log_err[b+1], 0);

    // Stale done flag held into the first WAIT cycle
    stale_hi = 1'b1;
    b = log_g.size();
    gb = grant_q.size();
    post(3, 200, 3);
    wait_grant(gb + 1, 20);
    step(); step();
    stale_hi = 1'b0;
    wait_resp(b + 1, 60);
    check_val("t6_result", log_res[b], 600);
    check_val("t6_error", log_err[b], 0);

    // Reset while waiting on the multiplier
    b = log_g.size();
    post(1, 2, 2);
    wait_resp(b + 1, 60);
    gb = grant_q.size();
    post(1, 4, 4);
    wait_grant(gb + 1, 20);
    repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    check_val("t7_respValid", respValid, 0);
    check_val("t7_mulRst", mulRst, 1);
    check_val("t7_busy", busy, 0);
    repeat (3) step();
    check_val("t7_dropped", log_g.size(), b + 1);
    b = log_g.size();
    post(0, 6, 7); post(2, 5, 5);
    wait_resp(b + 2, 120);
    check_val("t7_grant", log_g[b], 0);
    check_val("t7_result", log_res[b], 42);
    check_val("t7_grant2", log_g[b+1], 2);
    check_val("t7_result2", log_res[b+1], 25);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_arbiter.md
# shift_add_mult_arbiter

Round-robin scheduler that shares one sequential shift-add multiplier between `NUM_REQ` requesters. It accepts operand pairs over a valid/ready handshake and drives the multiplier's operand and restart inputs. It waits for the multiplier's done flag, or for a timeout, and returns the product to the granted requester. It sits between client blocks and the single multiplier instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand width; product is `2*WIDTH`.
- `TIMEOUT`, 64: maximum WAIT cycles before abort, ≥ `WIDTH+4`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqValid` in `NUM_REQ`: per-requester request.
- `reqA` in `NUM_REQ*WIDTH`: multiplicand, slice i belongs to requester i.
- `reqB` in `NUM_REQ*WIDTH`: multiplier, slice i belongs to requester i.
- `reqReady` out `NUM_REQ`: one-cycle accept pulse, one-hot.
- `respValid` out `NUM_REQ`: one-cycle result pulse, one-hot.
- `respResult` out `2*WIDTH`: product, valid with `respValid`.
- `respError` out 1: timeout flag, valid with `respValid`.
- `busy` out 1: high in every state except IDLE.
- `mulRst` out 1: restart/hold to the multiplier's `rst`.
- `mulA` out `WIDTH`: to the multiplier's multiplicand input.
- `mulB` out `WIDTH`: to the multiplier's multiplier input.
- `mulEnd` in 1: multiplier done flag.
- `mulResult` in `2*WIDTH`: multiplier product.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE: `mulRst`=1. If any `reqValid`, grant the first set bit at or after `rrPtr` (circular search).
  - Pulse `reqReady[g]` for that cycle.
  - Latch `reqA`/`reqB` slice g into `mulA`/`mulB`, store g, then go to START.
- START: `mulRst`=1 while operands settle. Clear the wait counter. Go to WAIT.
- WAIT: `mulRst`=0. Counter increments every cycle.
  - `mulEnd` is ignored in the first WAIT cycle, because the flag may be stale from before the restart.
  - From the second cycle on, `mulEnd`=1 captures `mulResult`, sets error=0, and moves to DONE.
  - If the counter reaches `TIMEOUT` without `mulEnd`, capture 0, set error=1, and move to DONE.
  - If `mulEnd` and timeout happen in the same cycle, `mulEnd` wins.
- DONE: `mulRst`=1. Pulse `respValid[g]`, with `respResult`/`respError` driven from the captured values.
  - Set `rrPtr` = (g+1) mod `NUM_REQ`. Go to IDLE.
- `respResult`/`respError` hold their last values after DONE until the next DONE.
- Requester rule:
  - Hold `reqValid` and the operands stable until `reqReady` is seen.
  - Deasserting `reqValid` before grant withdraws the request without error.
  - One outstanding request per requester.
- Operands are held internally for the whole transaction; later changes on `reqA`/`reqB` have no effect.
- Product is the unsigned `2*WIDTH`-bit value; no truncation.

## Timing
- Reset values: `reqReady`=0, `respValid`=0, `respResult`=0, `respError`=0, `busy`=0, `mulRst`=1, `mulA`=0, `mulB`=0. State is IDLE, `rrPtr`=0, counter=0.
- Reset mid-transaction returns to IDLE next cycle. The pending request is dropped (no `respValid`), `rrPtr` is reset to 0, and `mulRst`=1.
- Accept at cycle T (IDLE). START is T+1. WAIT begins T+2.
- `mulEnd` sampled high at cycle K (K ≥ T+3) gives `respValid` at K+1.
- Timeout gives `respValid` at T+2+`TIMEOUT`.
- Back-to-back: next accept happens no earlier than the cycle after DONE. At most one transaction is in flight.
- `reqReady` and `respValid` are never high in the same cycle. Each is never high for more than one bit.

## Test plan
- Requester 1 sends A=3, B=5 with a compliant multiplier model:
  - `reqReady[1]` is a single pulse, `mulA`=3 and `mulB`=5 during WAIT.
  - `respValid[1]` one cycle after `mulEnd`, `respResult`=15, `respError`=0.
- All 4 requesters assert together after reset, with operands (10,12), (127,201), (255,255), (0,77):
  - Grants in order 0,1,2,3.
  - Results 120, 25527, 65025, 0 on the matching `respValid` bits.
- Round-robin check: after a grant to 2, requesters 0 and 3 both request.
  - 3 is granted before 0.
  - Repeat with continuous requests on all four; no requester waits more than 3 transactions.
- Timeout with `TIMEOUT`=16 and a model that never raises `mulEnd`:
  - `respValid` at accept+18, `respError`=1, `respResult`=0.
  - The next request completes normally.
- Stale done: `mulEnd` held high into the first WAIT cycle is ignored, and the result is taken on the next asserted `mulEnd`.
- Assert `rst` during WAIT:
  - No `respValid` is produced and `mulRst`=1 on the next cycle.
  - After release, a new request for A=6, B=7 returns 42, with grant searching from requester 0.
